// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, RAM handshake states and arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_DGNT, ARB_IGNT} arbstate_t;

endpackage

// File: rtl/ram_request_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and data load/store.
// Data wins in IDLE unless a pending fetch has been starved STARVE_MAX times.
module ram_request_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ram_err
);

  arbstate_t        state;
  arbstate_t        next_state;
  logic [CNT_W-1:0] starve_cnt;
  ramstate_t        rs;
  logic             d_req;
  logic             starved;

  assign rs      = ramstate_t'(ramstate);
  assign d_req   = dREN | dWEN;
  assign starved = iREN && (starve_cnt == CNT_W'(STARVE_MAX));
  assign iload   = ramload;
  assign dload   = ramload;

  // Next-state decision; a dropped request, completion or error all return to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: begin
        if (d_req && !starved) begin
          next_state = ARB_DGNT;
        end else if (iREN) begin
          next_state = ARB_IGNT;
        end else begin
          next_state = ARB_IDLE;
        end
      end
      ARB_DGNT: begin
        if (!d_req || rs == ACCESS || rs == ERROR) begin
          next_state = ARB_IDLE;
        end else begin
          next_state = ARB_DGNT;
        end
      end
      ARB_IGNT: begin
        if (!iREN || rs == ACCESS || rs == ERROR) begin
          next_state = ARB_IDLE;
        end else begin
          next_state = ARB_IGNT;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // RAM-side mux and wait/error handshake; enables follow the owner's live request.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ram_err  = 1'b0;
    case (state)
      ARB_DGNT: begin
        if (d_req) begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          dwait    = (rs != ACCESS);
          ram_err  = (rs == ERROR);
        end else begin
          ramREN = 1'b0;
        end
      end
      ARB_IGNT: begin
        if (iREN) begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          iwait   = (rs != ACCESS);
          ram_err = (rs == ERROR);
        end else begin
          ramREN = 1'b0;
        end
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  // Starvation counter: counts data completions that happen while a fetch is waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (!iREN) begin
      starve_cnt <= '0;
    end else if (state == ARB_IGNT && rs == ACCESS) begin
      starve_cnt <= '0;
    end else if (state == ARB_DGNT && d_req && rs == ACCESS &&
                 starve_cnt != CNT_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

endmodule

// File: tb/tb_ram_request_arbiter.sv
// Directed bench for ram_request_arbiter; completions are checked by a scoreboard monitor.
module tb_ram_request_arbiter;

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;
  localparam logic [1:0] K_I = 2'd0, K_D = 2'd1, K_E = 2'd2, K_X = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ramREN, ramWEN, iwait, dwait, ram_err;
  logic [31:0] ramaddr, ramstore, iload, dload;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  ram_request_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: any completion or error pulse must match the oldest expected event.
  initial begin
    logic [1:0] k;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1 && (iwait !== 1'b1 || dwait !== 1'b1 || ram_err !== 1'b0)) begin
        if (!iwait && dwait && !ram_err)      k = K_I;
        else if (!dwait && iwait && !ram_err) k = K_D;
        else if (ram_err && iwait && dwait)   k = K_E;
        else                                  k = K_X;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got kind=%0d addr=%h want none", k, ramaddr);
        end else begin
          e = sb.pop_front();
          if (k != e.kind || ramaddr !== e.addr ||
              (k == K_I && iload !== e.data) || (k == K_D && dload !== e.data)) begin
            bad++;
            $display("FAIL completion: got kind=%0d addr=%h iload=%h dload=%h want kind=%0d addr=%h data=%h",
                     k, ramaddr, iload, dload, e.kind, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
    ramstate = RS_FREE; ramload = 32'h0000_1234;
    #2;
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_waits", {30'd0, iwait, dwait}, 32'd3);
    chk("rst_ram_err", 32'(ram_err), 32'd0);
    chk("rst_iload", iload, 32'h0000_1234);
    chk("rst_dload", dload, 32'h0000_1234);
    step();
    nRST = 1'b1;

    // 1: plain fetch, ACCESS on the second grant cycle
    iREN = 1'b1; iaddr = 32'h0000_0100; ramstate = RS_BUSY;
    mid(); chk("t1_idle_ren", 32'(ramREN), 32'd0);
    step();
    mid(); chk("t1_g1_ren", 32'(ramREN), 32'd1); chk("t1_g1_addr", ramaddr, 32'h100);
    chk("t1_g1_iwait", 32'(iwait), 32'd1);
    step();
    ramstate = RS_ACCESS; ramload = 32'h3C01_0001; push(K_I, 32'h100, 32'h3C01_0001);
    mid(); chk("t1_g2_ren", 32'(ramREN), 32'd1);
    step();
    iREN = 1'b0; ramstate = RS_FREE;
    mid(); chk("t1_after_ren", 32'(ramREN), 32'd0); chk("t1_after_iwait", 32'(iwait), 32'd1);
    step();

    // 2: simultaneous fetch and write, data first
    iREN = 1'b1; iaddr = 32'h104; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
    mid(); step();
    ramstate = RS_BUSY;
    mid(); chk("t2_wen", 32'(ramWEN), 32'd1); chk("t2_ren", 32'(ramREN), 32'd0);
    chk("t2_store", ramstore, 32'hDEAD_BEEF); chk("t2_addr", ramaddr, 32'h200);
    step();
    ramstate = RS_ACCESS; ramload = 32'h0000_0022; push(K_D, 32'h200, 32'h22);
    mid(); step();
    dWEN = 1'b0; ramstate = RS_FREE;
    mid(); chk("t2_dead_ren", 32'(ramREN), 32'd0); chk("t2_dead_wen", 32'(ramWEN), 32'd0);
    step();
    ramstate = RS_ACCESS; ramload = 32'h0000_0024; push(K_I, 32'h104, 32'h24);
    mid(); chk("t2_ignt_addr", ramaddr, 32'h104);
    step();
    iREN = 1'b0; ramstate = RS_FREE;
    mid(); step();

    // 3: fetch starved by continuous data reads
    iREN = 1'b1; iaddr = 32'h108; dREN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      daddr = 32'h400 + 32'(k) * 32'd4; ramstate = RS_FREE;
      mid(); chk("t3_idle_ren", 32'(ramREN), 32'd0);
      step();
      ramstate = RS_ACCESS; ramload = 32'hA0 + 32'(k); push(K_D, daddr, 32'hA0 + 32'(k));
      mid(); chk("t3_dgnt_addr", ramaddr, daddr);
      step();
    end
    ramstate = RS_FREE;
    mid(); chk("t3_cnt_sat", 32'(dut.starve_cnt), 32'd4);
    step();
    ramstate = RS_ACCESS; ramload = 32'h0000_00B0; push(K_I, 32'h108, 32'hB0);
    mid(); chk("t3_forced_fetch", ramaddr, 32'h108); chk("t3_forced_wen", 32'(ramWEN), 32'd0);
    step();
    ramstate = RS_FREE;
    mid(); chk("t3_cnt_clr", 32'(dut.starve_cnt), 32'd0);
    step();
    ramstate = RS_ACCESS; ramload = 32'h0000_00C0; push(K_D, 32'h40C, 32'hC0);
    mid(); chk("t3_data_again", ramaddr, 32'h40C);
    step();
    iREN = 1'b0; dREN = 1'b0; ramstate = RS_FREE;
    mid(); chk("t3_cnt_one", 32'(dut.starve_cnt), 32'd1);
    step();
    mid(); chk("t3_cnt_idle_clr", 32'(dut.starve_cnt), 32'd0);
    step();

    // 4: async reset during a busy fetch
    iREN = 1'b1; iaddr = 32'h500; ramstate = RS_BUSY;
    mid(); step();
    mid(); chk("t4_pre_ren", 32'(ramREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("t4_rst_ren", 32'(ramREN), 32'd0); chk("t4_rst_addr", ramaddr, 32'd0);
    chk("t4_rst_iwait", 32'(iwait), 32'd1);
    step();
    iREN = 1'b0; nRST = 1'b1; ramstate = RS_FREE;
    mid(); chk("t4_state", 32'(dut.state), 32'd0); chk("t4_post_ren", 32'(ramREN), 32'd0);
    step();

    // 5: error on a data read, then re-grant
    dREN = 1'b1; daddr = 32'h300;
    mid(); step();
    ramstate = RS_ERROR; push(K_E, 32'h300, 32'd0);
    mid(); chk("t5_ren", 32'(ramREN), 32'd1); chk("t5_err", 32'(ram_err), 32'd1);
    chk("t5_dwait", 32'(dwait), 32'd1);
    step();
    ramstate = RS_FREE;
    mid(); chk("t5_err_gone", 32'(ram_err), 32'd0); chk("t5_idle_ren", 32'(ramREN), 32'd0);
    step();
    ramstate = RS_ACCESS; ramload = 32'h0000_00D5; push(K_D, 32'h300, 32'hD5);
    mid(); chk("t5_regrant", ramaddr, 32'h300);
    step();
    dREN = 1'b0; ramstate = RS_FREE;
    mid(); step();

    // 6: data request withdrawn mid-grant, pending fetch follows
    dREN = 1'b1; daddr = 32'h600; iREN = 1'b1; iaddr = 32'h604; ramstate = RS_BUSY;
    mid(); step();
    mid(); chk("t6_g1_ren", 32'(ramREN), 32'd1); chk("t6_g1_addr", ramaddr, 32'h600);
    step();
    dREN = 1'b0;
    mid(); chk("t6_drop_ren", 32'(ramREN), 32'd0); chk("t6_drop_dwait", 32'(dwait), 32'd1);
    step();
    mid(); chk("t6_idle_ren", 32'(ramREN), 32'd0);
    step();
    ramstate = RS_ACCESS; ramload = 32'h0000_00E6; push(K_I, 32'h604, 32'hE6);
    mid(); chk("t6_fetch_addr", ramaddr, 32'h604);
    step();
    iREN = 1'b0; ramstate = RS_FREE;
    mid(); step();
    mid();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
